// File: rtl/btb_pkg.sv
// Shared widths, entry layout and tag folding for the set-associative BTB.
package btb_pkg;

    localparam int BTB_ADDR_W = 32;
    localparam int BTB_SETS   = 64;
    localparam int BTB_WAYS   = 2;
    localparam int BTB_TAG_W  = 10;

    localparam int IDX_W   = $clog2(BTB_SETS);
    localparam int WAY_W   = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam int ENTRY_W = 1 + BTB_TAG_W + BTB_ADDR_W;
    localparam int PC_INC  = 4;

    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_ADDR_W-1:0] target;
    } btb_entry_t;

    // Bit b of pc[addr_w-1:idx_w+2] lands in tag bit (b-idx_w-2) mod tag_w,
    // which is the XOR of successive zero-padded tag_w-bit slices.
    function automatic logic [63:0] fold_tag(input logic [63:0] pc,
                                             input int addr_w,
                                             input int idx_w,
                                             input int tag_w);
        logic [63:0] f;
        f = '0;
        for (int b = 0; b < 64; b++) begin
            if (b >= idx_w + 2 && b < addr_w && ((pc >> b) & 64'd1) != 64'd0)
                f = f ^ (64'd1 << ((b - idx_w - 2) % tag_w));
        end
        return f;
    endfunction

endpackage

// File: rtl/btb_way_array.sv
// One way of the BTB: per-set valid bits plus tag/target storage.
// Two combinational read ports (lookup and update probe), one write port.
module btb_way_array #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 64,
    parameter int TAG_W  = 10,
    localparam int IDX_BITS = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [ADDR_W-1:0]   rd_target,
    input  logic [IDX_BITS-1:0] probe_idx,
    output logic                probe_valid,
    output logic [TAG_W-1:0]    probe_tag,
    input  logic                wr_en,
    input  logic                inv_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [ADDR_W-1:0]   wr_target
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [ADDR_W-1:0] tgt_mem [SETS];

    always_ff @(posedge clk) begin
        if (reset || clear)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
        else if (inv_en)
            valid_q[wr_idx] <= 1'b0;
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_valid    = valid_q[rd_idx];
    assign rd_tag      = tag_mem[rd_idx];
    assign rd_target   = tgt_mem[rd_idx];
    assign probe_valid = valid_q[probe_idx];
    assign probe_tag   = tag_mem[probe_idx];

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: 1-cycle registered lookup returning
// target or pc+4, single training port with round-robin victim per set.
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int ADDR_W = BTB_ADDR_W,
    parameter int SETS   = BTB_SETS,
    parameter int WAYS   = BTB_WAYS,
    parameter int TAG_W  = BTB_TAG_W,
    localparam int IDX_BITS = $clog2(SETS),
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lk_valid,
    input  logic [ADDR_W-1:0]   lk_pc,
    output logic                lk_rsp_valid,
    output logic                lk_hit,
    output logic [WAY_BITS-1:0] lk_way,
    output logic [ADDR_W-1:0]   lk_next_pc,
    input  logic                upd_valid,
    input  logic [ADDR_W-1:0]   upd_pc,
    input  logic [ADDR_W-1:0]   upd_target,
    input  logic                upd_taken,
    input  logic                flush
);

    logic [IDX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]    lk_tag, upd_tag;

    assign lk_idx  = lk_pc[IDX_BITS+1:2];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign lk_tag  = TAG_W'(fold_tag(64'(lk_pc), ADDR_W, IDX_BITS, TAG_W));
    assign upd_tag = TAG_W'(fold_tag(64'(upd_pc), ADDR_W, IDX_BITS, TAG_W));

    logic [WAYS-1:0]   lk_vbit, up_vbit, wr_en, inv_en;
    logic [TAG_W-1:0]  lk_tagv [WAYS];
    logic [TAG_W-1:0]  up_tagv [WAYS];
    logic [ADDR_W-1:0] lk_tgtv [WAYS];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        btb_way_array #(.ADDR_W(ADDR_W), .SETS(SETS), .TAG_W(TAG_W)) u_way (
            .clk        (clk),
            .reset      (reset),
            .clear      (flush),
            .rd_idx     (lk_idx),
            .rd_valid   (lk_vbit[g]),
            .rd_tag     (lk_tagv[g]),
            .rd_target  (lk_tgtv[g]),
            .probe_idx  (upd_idx),
            .probe_valid(up_vbit[g]),
            .probe_tag  (up_tagv[g]),
            .wr_en      (wr_en[g]),
            .inv_en     (inv_en[g]),
            .wr_idx     (upd_idx),
            .wr_tag     (upd_tag),
            .wr_target  (upd_target)
        );
    end

    logic                lk_any;
    logic [WAY_BITS-1:0] lk_sel_way;
    logic [ADDR_W-1:0]   lk_sel_tgt;

    always_comb begin
        lk_any     = 1'b0;
        lk_sel_way = '0;
        lk_sel_tgt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_vbit[w] && lk_tagv[w] == lk_tag) begin
                lk_any     = 1'b1;
                lk_sel_way = WAY_BITS'(w);
                lk_sel_tgt = lk_tgtv[w];
            end
        end
    end

    logic [SETS-1:0][WAY_BITS-1:0] vp_q;
    logic [WAYS-1:0]     up_hitv;
    logic                up_any, inv_any;
    logic [WAY_BITS-1:0] up_way, first_inv, victim;

    always_comb begin
        up_hitv   = '0;
        up_way    = '0;
        inv_any   = 1'b0;
        first_inv = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            up_hitv[w] = up_vbit[w] && up_tagv[w] == upd_tag;
            if (up_hitv[w])
                up_way = WAY_BITS'(w);
            if (!up_vbit[w]) begin
                inv_any   = 1'b1;
                first_inv = WAY_BITS'(w);
            end
        end
        up_any = |up_hitv;
        victim = inv_any ? first_inv : vp_q[upd_idx];
        for (int w = 0; w < WAYS; w++) begin
            wr_en[w]  = upd_valid && upd_taken && !flush &&
                        (up_any ? (up_way == WAY_BITS'(w)) : (victim == WAY_BITS'(w)));
            inv_en[w] = upd_valid && !upd_taken && !flush && up_hitv[w];
        end
    end

    // Pointer advances only when a valid way was actually evicted.
    always_ff @(posedge clk) begin
        if (reset || flush)
            vp_q <= '0;
        else if (upd_valid && upd_taken && !up_any && !inv_any)
            vp_q[upd_idx] <= (WAYS == 1) ? '0 : WAY_BITS'(victim + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_rsp_valid <= 1'b0;
            lk_hit       <= 1'b0;
            lk_way       <= '0;
            lk_next_pc   <= '0;
        end else begin
            lk_rsp_valid <= lk_valid;
            if (lk_valid) begin
                lk_hit     <= lk_any;
                lk_way     <= lk_sel_way;
                lk_next_pc <= lk_any ? lk_sel_tgt : lk_pc + ADDR_W'(PC_INC);
            end
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc: directed scenarios plus random traffic, all checked
// against an array-of-sets reference model with its own slice-wise tag fold.
module tb_btb_set_assoc;

    logic        clk = 1'b0;
    logic        reset, lk_valid, upd_valid, upd_taken, flush;
    logic [31:0] lk_pc, upd_pc, upd_target;
    logic        lk_rsp_valid, lk_hit;
    logic [0:0]  lk_way;
    logic [31:0] lk_next_pc;

    always #5 clk = ~clk;

    btb_set_assoc dut (
        .clk         (clk),
        .reset       (reset),
        .lk_valid    (lk_valid),
        .lk_pc       (lk_pc),
        .lk_rsp_valid(lk_rsp_valid),
        .lk_hit      (lk_hit),
        .lk_way      (lk_way),
        .lk_next_pc  (lk_next_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .flush       (flush)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 64 sets x 2 ways, plus the expected output registers.
    bit          m_v  [64][2];
    logic [9:0]  m_t  [64][2];
    logic [31:0] m_g  [64][2];
    int          m_vp [64];
    logic        e_v, e_hit;
    logic [0:0]  e_way;
    logic [31:0] e_next;

    function automatic logic [9:0] ref_tag(input logic [31:0] pc);
        logic [31:0] up;
        logic [9:0]  r;
        up = pc >> 8;
        r  = '0;
        for (int s = 0; s < 3; s++)
            r = r ^ 10'((up >> (10 * s)) & 32'h3FF);
        return r;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 64; s++) begin
            m_v[s][0] = 1'b0;
            m_v[s][1] = 1'b0;
            m_vp[s]   = 0;
        end
    endfunction

    function automatic int model_find(input logic [31:0] pc);
        int s;
        s = int'((pc >> 2) & 32'h3F);
        for (int w = 0; w < 2; w++)
            if (m_v[s][w] && m_t[s][w] == ref_tag(pc)) return w;
        return -1;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt,
                                         input bit taken);
        int s, w, vic;
        s = int'((pc >> 2) & 32'h3F);
        w = model_find(pc);
        if (taken && w >= 0) begin
            m_g[s][w] = tgt;
        end else if (taken) begin
            if (!m_v[s][0])      vic = 0;
            else if (!m_v[s][1]) vic = 1;
            else begin
                vic     = m_vp[s];
                m_vp[s] = (m_vp[s] + 1) % 2;
            end
            m_v[s][vic] = 1'b1;
            m_t[s][vic] = ref_tag(pc);
            m_g[s][vic] = tgt;
        end else if (w >= 0) begin
            m_v[s][w] = 1'b0;
        end
    endfunction

    // Applies one cycle of stimulus, advances the model, and returns at
    // posedge+1 when the DUT response for that cycle is visible.
    task automatic drive(input bit lkv, input logic [31:0] lpc,
                         input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                         input bit ut, input bit fl, input bit rst);
        int w;
        reset = rst; lk_valid = lkv; lk_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut; flush = fl;
        if (rst) begin
            e_v = 1'b0; e_hit = 1'b0; e_way = '0; e_next = '0;
            model_clear();
        end else begin
            e_v = lkv;
            if (lkv) begin
                w      = model_find(lpc);
                e_hit  = (w >= 0);
                e_way  = (w >= 0) ? 1'(w) : 1'b0;
                e_next = (w >= 0) ? m_g[int'((lpc >> 2) & 32'h3F)][w] : lpc + 32'd4;
            end
            if (fl)      model_clear();
            else if (uv) model_update(upc, utgt, ut);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
        drive(1'b0, 32'h0, 1'b1, pc, tgt, taken, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        total++;
        if ({lk_rsp_valid, lk_hit, lk_way, lk_next_pc} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0", {lk_rsp_valid, lk_hit, lk_way, lk_next_pc});
        end
        lookup(32'h0000_1000);
        total++;
        if ({lk_rsp_valid, lk_hit, lk_way, lk_next_pc} !== {1'b1, 1'b0, 1'b0, 32'h0000_1004}) begin
            bad++;
            $display("FAIL first_miss got %h want %h", {lk_rsp_valid, lk_hit, lk_way, lk_next_pc},
                     {1'b1, 1'b0, 1'b0, 32'h0000_1004});
        end
    endtask

    task automatic test_update_bypass();
        drive(1'b1, 32'h1000, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0, 1'b0);
        total++;
        if ({lk_rsp_valid, lk_hit, lk_next_pc} !== {1'b1, 1'b0, 32'h1004}) begin
            bad++;
            $display("FAIL no_bypass got %h want %h", {lk_rsp_valid, lk_hit, lk_next_pc}, {1'b1, 1'b0, 32'h1004});
        end
        lookup(32'h1000);
        total++;
        if ({lk_rsp_valid, lk_hit, lk_next_pc} !== {1'b1, 1'b1, 32'h2000}) begin
            bad++;
            $display("FAIL trained_hit got %h want %h", {lk_rsp_valid, lk_hit, lk_next_pc}, {1'b1, 1'b1, 32'h2000});
        end
    endtask

    task automatic test_replace();
        logic [31:0] pcs [3] = '{32'h1000, 32'h1100, 32'h1200};
        do_reset();
        train(32'h1000, 32'hA000, 1'b1);
        train(32'h1100, 32'hB000, 1'b1);
        train(32'h1200, 32'hC000, 1'b1);
        foreach (pcs[i]) begin
            lookup(pcs[i]);
            total++;
            if ({lk_rsp_valid, lk_hit, lk_way, lk_next_pc} !== {e_v, e_hit, e_way, e_next}) begin
                bad++;
                $display("FAIL replace_%0d got %h want %h", i, {lk_rsp_valid, lk_hit, lk_way, lk_next_pc},
                         {e_v, e_hit, e_way, e_next});
            end
        end
        total++;
        if ({lk_hit, lk_way, lk_next_pc} !== {1'b1, 1'b0, 32'hC000}) begin
            bad++;
            $display("FAIL replace_way0 got %h want %h", {lk_hit, lk_way, lk_next_pc}, {1'b1, 1'b0, 32'hC000});
        end
    endtask

    task automatic test_retrain();
        logic [31:0] pcs [4] = '{32'h1100, 32'h1200, 32'h1300, 32'h1000};
        train(32'h1100, 32'h3000, 1'b1);
        lookup(32'h1100);
        total++;
        if ({lk_hit, lk_way, lk_next_pc} !== {1'b1, 1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL retrain got %h want %h", {lk_hit, lk_way, lk_next_pc}, {1'b1, 1'b1, 32'h3000});
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({lk_rsp_valid, lk_hit, lk_way, lk_next_pc} !== {1'b0, 1'b1, 1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL idle_hold got %h want %h", {lk_rsp_valid, lk_hit, lk_way, lk_next_pc},
                     {1'b0, 1'b1, 1'b1, 32'h3000});
        end
        // vp was left at 1 by the earlier eviction, so this evicts 0x1100 from way 1.
        train(32'h1300, 32'hD000, 1'b1);
        foreach (pcs[i]) begin
            lookup(pcs[i]);
            total++;
            if ({lk_rsp_valid, lk_hit, lk_way, lk_next_pc} !== {e_v, e_hit, e_way, e_next}) begin
                bad++;
                $display("FAIL vp_evict_%0d got %h want %h", i, {lk_rsp_valid, lk_hit, lk_way, lk_next_pc},
                         {e_v, e_hit, e_way, e_next});
            end
        end
        train(32'h1300, 32'h0, 1'b0);
        lookup(32'h1300);
        total++;
        if ({lk_rsp_valid, lk_hit, lk_next_pc} !== {1'b1, 1'b0, 32'h1304}) begin
            bad++;
            $display("FAIL not_taken_inv got %h want %h", {lk_rsp_valid, lk_hit, lk_next_pc}, {1'b1, 1'b0, 32'h1304});
        end
    endtask

    task automatic test_flush();
        logic [31:0] pcs [5] = '{32'h4000, 32'h4104, 32'h4208, 32'h430C, 32'h5000};
        do_reset();
        for (int i = 0; i < 4; i++) train(pcs[i], 32'h8000 + 32'(i * 16), 1'b1);
        drive(1'b1, 32'h4000, 1'b1, 32'h5000, 32'h9000, 1'b1, 1'b1, 1'b0);
        total++;
        if ({lk_hit, lk_next_pc} !== {1'b1, 32'h8000}) begin
            bad++;
            $display("FAIL flush_prelookup got %h want %h", {lk_hit, lk_next_pc}, {1'b1, 32'h8000});
        end
        foreach (pcs[i]) begin
            lookup(pcs[i]);
            total++;
            if ({lk_rsp_valid, lk_hit, lk_next_pc} !== {1'b1, 1'b0, pcs[i] + 32'd4}) begin
                bad++;
                $display("FAIL flush_miss_%0d got %h want %h", i, {lk_rsp_valid, lk_hit, lk_next_pc},
                         {1'b1, 1'b0, pcs[i] + 32'd4});
            end
        end
    endtask

    task automatic test_wrap_reset();
        lookup(32'hFFFF_FFFC);
        total++;
        if ({lk_hit, lk_next_pc} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL wrap got %h want %h", {lk_hit, lk_next_pc}, {1'b0, 32'h0});
        end
        train(32'h1000, 32'h2000, 1'b1);
        drive(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        total++;
        if (lk_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_squash got %b want 0", lk_rsp_valid);
        end
        lookup(32'h1000);
        total++;
        if ({lk_rsp_valid, lk_hit, lk_next_pc} !== {1'b1, 1'b0, 32'h1004}) begin
            bad++;
            $display("FAIL reset_clears got %h want %h", {lk_rsp_valid, lk_hit, lk_next_pc}, {1'b1, 1'b0, 32'h1004});
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi [3] = '{32'h0, 32'h1234_0000, 32'hFFFF_0000};
        return hi[$urandom_range(0, 2)] | (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 1) != 0, rand_pc(),
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
            total++;
            if ({lk_rsp_valid, lk_hit, lk_way, lk_next_pc} !== {e_v, e_hit, e_way, e_next}) begin
                bad++;
                $display("FAIL random_%0d got %h want %h", n, {lk_rsp_valid, lk_hit, lk_way, lk_next_pc},
                         {e_v, e_hit, e_way, e_next});
            end
        end
    endtask

    initial begin
        reset = 1'b1; lk_valid = 1'b0; lk_pc = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0; flush = 1'b0;
        e_v = 1'b0; e_hit = 1'b0; e_way = '0; e_next = '0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_update_bypass();
        test_replace();
        test_retrain();
        test_flush();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
